// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: main control FSM of the multicycle LEGv8 core
module legv8_multicycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [3:0]  ALUOp,
  output logic [1:0]  SignOp,
  output logic        insn_done,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  fault
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BR_B, BR_CBZ, HALT
  } state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] retired_q, retired_d;
  logic is_add, is_sub, is_and, is_orr, is_addi, is_subi, is_ldur, is_stur, is_b, is_cbz;
  logic is_r, is_i, mem_st, waiting, tmo;
  assign is_add  = Opcode == 11'b10001011000;
  assign is_sub  = Opcode == 11'b11001011000;
  assign is_and  = Opcode == 11'b10001010000;
  assign is_orr  = Opcode == 11'b10101010000;
  assign is_addi = Opcode[10:1] == 10'b1001000100;
  assign is_subi = Opcode[10:1] == 10'b1101000100;
  assign is_ldur = Opcode == 11'b11111000010;
  assign is_stur = Opcode == 11'b11111000000;
  assign is_b    = Opcode[10:5] == 6'b000101;
  assign is_cbz  = Opcode[10:3] == 8'b10110100;
  assign is_r    = is_add | is_sub | is_and | is_orr;
  assign is_i    = is_addi | is_subi;
  // the timeout counter only runs while a memory state is stalled on ack
  assign mem_st  = state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR;
  assign waiting = mem_st && !mem_ack;
  assign tmo     = waiting && (cnt_q + 8'd1 == TO);
  assign retired = retired_q;
  assign fault   = fault_q;
  assign halted  = resetl && state_q == HALT;
  // state, wait counter, fault code and retire count
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      fault_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end
  // next state; a memory timeout overrides every other transition
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    cnt_d     = waiting ? cnt_q + 8'd1 : 8'd0;
    retired_d = retired_q + {31'd0, insn_done};
    case (state_q)
      FETCH:   state_d = mem_ack ? DECODE : FETCH;
      DECODE: begin
        state_d = is_r ? EXEC_R : is_i ? EXEC_I : (is_ldur | is_stur) ? ADDR :
                  is_b ? BR_B : is_cbz ? BR_CBZ : HALT;
        fault_d = (is_r | is_i | is_ldur | is_stur | is_b | is_cbz) ? fault_q : 2'b01;
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      ADDR:    state_d = is_ldur ? MEM_RD : MEM_WR;
      MEM_RD:  state_d = mem_ack ? WB_MEM : MEM_RD;
      MEM_WR:  state_d = mem_ack ? FETCH : MEM_WR;
      WB_ALU, WB_MEM, BR_B, BR_CBZ: state_d = FETCH;
      default: state_d = HALT;
    endcase
    if (tmo) begin
      state_d = HALT;
      fault_d = 2'b10;
    end
  end
  // datapath controls; reset forces everything low without waiting for a clock
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    Reg2Loc   = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = 4'b0000;
    SignOp    = 2'b00;
    insn_done = 1'b0;
    if (resetl) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ack;
          PCWrite = mem_ack;
        end
        DECODE: begin
          Reg2Loc = is_stur | is_cbz;
          SignOp  = (is_ldur | is_stur) ? 2'b01 : is_b ? 2'b10 : is_cbz ? 2'b11 : 2'b00;
        end
        EXEC_R: ALUOp = is_sub ? 4'b0110 : is_and ? 4'b0000 : is_orr ? 4'b0001 : 4'b0010;
        EXEC_I: begin
          ALUSrc = 1'b1;
          ALUOp  = is_subi ? 4'b0110 : 4'b0010;
        end
        ADDR: begin
          ALUSrc  = 1'b1;
          SignOp  = 2'b01;
          ALUOp   = 4'b0010;
          Reg2Loc = is_stur;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WR: begin
          mem_req   = 1'b1;
          IorD      = 1'b1;
          mem_we    = 1'b1;
          Reg2Loc   = 1'b1;
          insn_done = mem_ack;
        end
        WB_ALU: begin
          RegWrite  = 1'b1;
          insn_done = 1'b1;
        end
        WB_MEM: begin
          RegWrite  = 1'b1;
          MemToReg  = 1'b1;
          insn_done = 1'b1;
        end
        BR_B: begin
          SignOp    = 2'b10;
          PCWrite   = 1'b1;
          PCSrc     = 1'b1;
          insn_done = 1'b1;
        end
        BR_CBZ: begin
          SignOp    = 2'b11;
          Reg2Loc   = 1'b1;
          ALUOp     = 4'b0111;
          PCWrite   = Zero;
          PCSrc     = 1'b1;
          insn_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: directed cycle-by-cycle check of the control FSM
module tb_legv8_multicycle_ctrl;
  logic        CLK = 1'b0;
  logic        resetl, Zero, mem_ack;
  logic [10:0] Opcode;
  logic        mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, RegWrite, MemToReg, ALUSrc;
  logic [3:0]  ALUOp;
  logic [1:0]  SignOp, fault;
  logic        insn_done, halted;
  logic [31:0] retired;
  logic [19:0] ctl;
  int n_chk = 0;
  int n_err = 0;

  legv8_multicycle_ctrl #(.TIMEOUT(4)) dut (
    .CLK(CLK), .resetl(resetl), .Opcode(Opcode), .Zero(Zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .SignOp(SignOp), .insn_done(insn_done),
    .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 CLK = ~CLK;

  // {mem_req,mem_we,IorD,IRWrite,PCWrite,PCSrc,Reg2Loc,RegWrite,MemToReg,ALUSrc,ALUOp,SignOp,insn_done,halted,fault}
  assign ctl = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, RegWrite, MemToReg,
                ALUSrc, ALUOp, SignOp, insn_done, halted, fault};

  localparam logic [19:0] IDLE   = 20'd0;
  localparam logic [19:0] F_ACK  = {10'b1001100000, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] F_WAIT = {10'b1000000000, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] D_LD   = {10'b0000000000, 4'b0000, 2'b01, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] D_ST   = {10'b0000001000, 4'b0000, 2'b01, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] D_CBZ  = {10'b0000001000, 4'b0000, 2'b11, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] D_B    = {10'b0000000000, 4'b0000, 2'b10, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] X_ADD  = {10'b0000000000, 4'b0010, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] X_ORR  = {10'b0000000000, 4'b0001, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] X_SUBI = {10'b0000000001, 4'b0110, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] WB_A   = {10'b0000000100, 4'b0000, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [19:0] A_LD   = {10'b0000000001, 4'b0010, 2'b01, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] A_ST   = {10'b0000001001, 4'b0010, 2'b01, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] M_RD   = {10'b1010000000, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] WB_M   = {10'b0000000110, 4'b0000, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [19:0] M_WR_A = {10'b1110001000, 4'b0000, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [19:0] M_WR_W = {10'b1110001000, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [19:0] BR_B   = {10'b0000110000, 4'b0000, 2'b10, 1'b1, 1'b0, 2'b00};
  localparam logic [19:0] CBZ_T  = {10'b0000111000, 4'b0111, 2'b11, 1'b1, 1'b0, 2'b00};
  localparam logic [19:0] CBZ_N  = {10'b0000011000, 4'b0111, 2'b11, 1'b1, 1'b0, 2'b00};
  localparam logic [19:0] H_ILL  = {10'b0000000000, 4'b0000, 2'b00, 1'b0, 1'b1, 2'b01};
  localparam logic [19:0] H_TO   = {10'b0000000000, 4'b0000, 2'b00, 1'b0, 1'b1, 2'b10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // check controls mid-cycle, then move to just after the next rising edge
  task automatic cyc(input string tag, input logic [19:0] exp);
    @(negedge CLK);
    check(tag, {12'd0, ctl}, {12'd0, exp});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int hits;
    resetl = 1'b0; mem_ack = 1'b1; Zero = 1'b0; Opcode = 11'b10001011000;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_ctl", {12'd0, ctl}, 32'd0);
    check("reset_retired", retired, 32'd0);
    resetl = 1'b1;
    // ADD
    cyc("add_fetch", F_ACK);
    cyc("add_decode", IDLE);
    cyc("add_exec", X_ADD);
    cyc("add_wb", WB_A);
    check("add_retired", retired, 32'd1);
    // LDUR with three data wait cycles
    Opcode = 11'b11111000010;
    cyc("ld_fetch", F_ACK);
    mem_ack = 1'b0;
    cyc("ld_decode", D_LD);
    cyc("ld_addr", A_LD);
    for (int i = 0; i < 3; i++) cyc("ld_wait", M_RD);
    mem_ack = 1'b1;
    cyc("ld_ack", M_RD);
    cyc("ld_wb", WB_M);
    check("ld_retired", retired, 32'd2);
    // CBZ taken then not taken
    Opcode = 11'b10110100000;
    cyc("cbz1_fetch", F_ACK);
    cyc("cbz1_decode", D_CBZ);
    Zero = 1'b1;
    cyc("cbz1_br", CBZ_T);
    check("cbz1_retired", retired, 32'd3);
    cyc("cbz0_fetch", F_ACK);
    cyc("cbz0_decode", D_CBZ);
    Zero = 1'b0;
    cyc("cbz0_br", CBZ_N);
    check("cbz0_retired", retired, 32'd4);
    // B
    Opcode = 11'b00010100000;
    cyc("b_fetch", F_ACK);
    cyc("b_decode", D_B);
    cyc("b_br", BR_B);
    // STUR zero-wait
    Opcode = 11'b11111000000;
    cyc("st_fetch", F_ACK);
    cyc("st_decode", D_ST);
    cyc("st_addr", A_ST);
    cyc("st_mem", M_WR_A);
    check("st_retired", retired, 32'd6);
    // SUBI and ORR
    Opcode = 11'b11010001001;
    cyc("subi_fetch", F_ACK);
    cyc("subi_decode", IDLE);
    cyc("subi_exec", X_SUBI);
    cyc("subi_wb", WB_A);
    Opcode = 11'b10101010000;
    cyc("orr_fetch", F_ACK);
    cyc("orr_decode", IDLE);
    cyc("orr_exec", X_ORR);
    cyc("orr_wb", WB_A);
    check("orr_retired", retired, 32'd8);
    // reset in the middle of a stalled STUR
    Opcode = 11'b11111000000;
    cyc("st2_fetch", F_ACK);
    cyc("st2_decode", D_ST);
    cyc("st2_addr", A_ST);
    mem_ack = 1'b0;
    cyc("st2_wait", M_WR_W);
    #2;
    resetl = 1'b0;
    #1;
    check("st2_async_ctl", {12'd0, ctl}, 32'd0);
    check("st2_retired", retired, 32'd0);
    @(posedge CLK);
    #1;
    resetl = 1'b1;
    mem_ack = 1'b1;
    Opcode = 11'b11111111111;
    cyc("resume_fetch", F_ACK);
    // illegal opcode
    cyc("ill_decode", IDLE);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (mem_req) hits++;
    end
    check("ill_memreq", hits, 0);
    check("ill_halt", {12'd0, ctl}, {12'd0, H_ILL});
    // fetch timeout after four waiting cycles
    @(posedge CLK);
    #1;
    resetl = 1'b0;
    mem_ack = 1'b0;
    #2;
    check("rst_fault", {30'd0, fault}, 32'd0);
    resetl = 1'b1;
    for (int i = 0; i < 4; i++) cyc("to_wait", F_WAIT);
    cyc("to_halt", H_TO);
    #2;
    resetl = 1'b0;
    #1;
    check("to_rst_ctl", {12'd0, ctl}, 32'd0);
    check("to_rst_retired", retired, 32'd0);
    @(posedge CLK);
    #1;
    resetl = 1'b1;
    cyc("to_refetch", F_WAIT);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
